// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Fetch-stage branch predictor and target buffer. A direct-mapped table of
// ENTRIES entries, each holding {valid, tag, target, 2-bit saturating counter},
// is looked up combinationally with the fetch PC. The table is trained by the
// execute-stage prediction checker.
//
// Optional feature macro: BTB_STATS_EN
//   defined   -> lookup / hit / mispredict performance counters are built
//   undefined -> counters are absent, stat_* outputs are tied to 0 and
//                misprediction / stat_clr are ignored
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   if_pc             fetch PC to look up
//   prediction        predicted taken for if_pc
//   btb_out           predicted next PC for if_pc
//   resolve_valid     a branch/jump resolves in EX this cycle
//   resolve_pc        PC of the resolving instruction
//   resolve_jump      resolving instruction is JAL/JALR
//   resolve_taken     branch outcome (ignored for jumps)
//   resolve_target    computed target
//   load_btb          checker request to (re)allocate the entry
//   misprediction     checker mispredict flag (statistics only)
//   stat_clr          synchronous clear of the statistics counters
//   stat_lookups, stat_hits, stat_mispredicts   performance counters
// -----------------------------------------------------------------------------
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        prediction,
  output logic [31:0] btb_out,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_jump,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        load_btb,
  input  logic        misprediction,
  input  logic        stat_clr,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = 32 - IDX - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG-1:0]   tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Lookup path: purely combinational from if_pc and registered state, so an
  // update landing this edge is not seen until the next cycle (no bypass).
  logic [IDX-1:0] if_idx;
  logic [TAG-1:0] if_tag;
  logic           hit;

  assign if_idx     = if_pc[IDX+1:2];
  assign if_tag     = if_pc[31:IDX+2];
  assign hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign prediction = hit && ctr_q[if_idx][1];
  assign btb_out    = prediction ? target_q[if_idx] : if_pc + 32'd4;

  // Update path
  logic [IDX-1:0] rs_idx;
  logic [TAG-1:0] rs_tag;
  logic           rs_hit;
  logic           rs_t;

  assign rs_idx = resolve_pc[IDX+1:2];
  assign rs_tag = resolve_pc[31:IDX+2];
  assign rs_hit = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
  assign rs_t   = resolve_jump | resolve_taken;

  // NOTE: the table is built from flops, not a RAM macro, because every entry
  // must come out of reset invalid with ctr=01; a RAM cannot be reset in one go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (resolve_valid) begin
      if (load_btb) begin
        valid_q[rs_idx]  <= 1'b1;
        tag_q[rs_idx]    <= rs_tag;
        target_q[rs_idx] <= resolve_target;
        ctr_q[rs_idx]    <= resolve_jump ? 2'b11 : (rs_t ? 2'b10 : 2'b01);
      end else if (rs_hit) begin
        if (rs_t) begin
          if (ctr_q[rs_idx] != 2'b11) ctr_q[rs_idx] <= ctr_q[rs_idx] + 2'b01;
        end else begin
          if (ctr_q[rs_idx] != 2'b00) ctr_q[rs_idx] <= ctr_q[rs_idx] - 2'b01;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], resolve_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (stat_lookups != 32'hFFFF_FFFF)
        stat_lookups <= stat_lookups + 32'd1;
      if (hit && stat_hits != 32'hFFFF_FFFF)
        stat_hits <= stat_hits + 32'd1;
      if (misprediction && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], resolve_pc[1:0], misprediction, stat_clr};

  assign stat_lookups     = '0;
  assign stat_hits        = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage branch predictor and target buffer. It supplies `prediction` and the predicted target `btb_out` for the current fetch PC, and these travel down the pipeline to the execute-stage prediction checker. It consumes the checker's resolution (`load_btb`, `misprediction`) together with the resolved branch or jump outcome to train a direct-mapped table. Each table entry holds a tag, a target and a 2-bit saturating counter.

## Interface
Parameters:
- `ENTRIES`, 16: number of table entries. Must be a power of two and at least 2. `IDX = log2(ENTRIES)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `if_pc`  in  32  fetch PC to look up.
- `prediction`  out  1  predicted taken for `if_pc`.
- `btb_out`  out  32  predicted next PC for `if_pc`.
- `resolve_valid`  in  1  a branch or jump is resolving in EX this cycle.
- `resolve_pc`  in  32  PC of the resolving instruction.
- `resolve_jump`  in  1  the resolving instruction is JAL/JALR.
- `resolve_taken`  in  1  branch outcome (`br_en`). Ignored when `resolve_jump` is 1.
- `resolve_target`  in  32  computed target (`alu_out`).
- `load_btb`  in  1  checker request to (re)allocate the entry.
- `misprediction`  in  1  checker mispredict flag; used only for statistics.
- `stat_clr`  in  1  synchronous clear of the statistics counters.
- `stat_lookups`, `stat_hits`, `stat_mispredicts`  out  32 each  performance counters.

## Operation
- Index and tag:
  - index = `pc[IDX+1:2]`
  - tag = `pc[31:IDX+2]`
  - Per entry: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`.
- Lookup (combinational):
  - hit = `valid[idx] && tag[idx] == if_pc` tag.
  - `prediction = hit && ctr[idx][1]`.
  - `btb_out = prediction ? target[idx] : if_pc + 4`, with 32-bit wraparound.
- Update, at the edge where `resolve_valid` = 1. Let t = `resolve_jump | resolve_taken`.
  - If `load_btb` = 1: write valid = 1, the tag of `resolve_pc`, target = `resolve_target`, and ctr = 2'b11 for a jump, 2'b10 if t, else 2'b01.
  - Else, if the entry hits on `resolve_pc`: ctr saturating-increments if t, else saturating-decrements (floor 2'b00, ceiling 2'b11). A jump increments.
  - Else (miss, no load): no change.
- `load_btb` = 1 while `resolve_valid` = 0 is ignored.
- The statistics counters and `misprediction` are described under Configuration.

## Timing
- Lookup has zero latency from `if_pc`. Outputs depend only on `if_pc` and registered state.
- An update written at edge N is visible to lookups from cycle N+1.
- Same index looked up and updated in one cycle: the lookup returns the pre-update contents. There is no write-through bypass.
- Reset, asynchronous on `rst_n` low:
  - all `valid` bits = 0, all `ctr` = 2'b01, tags and targets = 0, statistics = 0.
  - Outputs during and after reset: `prediction` = 0, `btb_out` = `if_pc`+4, statistics outputs = 0.
- Reset asserted mid-update: the update is lost and the table is fully invalid.
- Aliasing: two PCs with the same index evict each other on `load_btb`. No associativity.

## Configuration
- `BTB_STATS_EN` defined:
  - Each cycle `stat_lookups` += 1 and `stat_hits` += hit.
  - `stat_mispredicts` += 1 when `misprediction` = 1.
  - All three saturate at 32'hFFFF_FFFF.
  - `stat_clr` = 1 zeroes all three at the edge and takes priority over increments in that cycle.
- `BTB_STATS_EN` undefined: the counters are not built, the outputs are constant 0, and `misprediction` and `stat_clr` are ignored.

## Test plan
- Reset, then any `if_pc` (e.g. 0x0000_0100): `prediction` = 0, `btb_out` = 0x0000_0104.
- Resolve at PC 0x40: `resolve_valid`=1, `load_btb`=1, taken, target 0x80. Then the next-cycle lookup of 0x40 gives `prediction`=1, `btb_out`=0x80. In the same edge's cycle, a lookup of 0x40 still misses.
- Entry at ctr 2'b10: two not-taken resolves with `load_btb`=0 → 2'b00 and `prediction` = 0. Three taken resolves → 2'b11 and holds there (saturation).
- With `ENTRIES`=16: allocate 0x40 → 0x80, then allocate 0x80 (same index, different tag) as a jump to 0x200. Lookup of 0x40 misses (`btb_out`=0x44); lookup of 0x80 gives 0x200 with `prediction`=1.
- Drop `rst_n` asynchronously mid-cycle after allocations: `prediction` falls to 0 immediately, without waiting for a clock edge.
- With `BTB_STATS_EN`: run 10 cycles, 4 of them hits, and 2 `misprediction` pulses → counters read 10/4/2. Pulse `stat_clr` → all 0 on the next cycle.
